// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic pipeline stage register.
// State encodings plus MEM/WB bundle field layout.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_state_e;

    localparam int MEMWB_PC4_W    = 32;
    localparam int MEMWB_ALUC_W   = 32;
    localparam int MEMWB_WR_W     = 5;
    localparam int MEMWB_RDO_W    = 32;
    localparam int MEMWB_WSEL_W   = 2;
    localparam int MEMWB_EXT_W    = 32;
    localparam int MEMWB_SPARE_W  = 2;

    localparam int MEMWB_PC4_LSB   = 0;
    localparam int MEMWB_ALUC_LSB  = MEMWB_PC4_LSB + MEMWB_PC4_W;
    localparam int MEMWB_WR_LSB    = MEMWB_ALUC_LSB + MEMWB_ALUC_W;
    localparam int MEMWB_RDO_LSB   = MEMWB_WR_LSB + MEMWB_WR_W;
    localparam int MEMWB_WSEL_LSB  = MEMWB_RDO_LSB + MEMWB_RDO_W;
    localparam int MEMWB_EXT_LSB   = MEMWB_WSEL_LSB + MEMWB_WSEL_W;
    localparam int MEMWB_SPARE_LSB = MEMWB_EXT_LSB + MEMWB_EXT_W;

    localparam int MEMWB_W = MEMWB_SPARE_LSB + MEMWB_SPARE_W;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot: payload+ctrl register with load
// enable and a valid bit; sync active-high reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         vld_d,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);

    // Valid follows the FSM every cycle; data only on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            vld <= vld_d;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with handshake, flush, ctrl kill.
// Define PIPE_STAGE_SKID_EN for the 2-entry registered-ready build.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_W,
    parameter int CTRL_W    = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int SW = PAYLOAD_W + CTRL_W;

    ps_state_e      state;
    ps_state_e      state_n;
    logic [SW-1:0]  main_d;
    logic [SW-1:0]  main_q;
    logic           main_vld;
    logic           ld_main;
    logic           in_xfer;
    logic           out_xfer;
    logic [CTRL_W-1:0] ctrl_main;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [SW-1:0] skid_q;
    logic          skid_vld;
    logic          ld_skid;

    assign in_ready = (state != PS_SKID);
    assign main_d   = skid_vld ? skid_q : {in_ctrl, in_data};

    pipe_slot #(
        .W (SW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (ld_skid),
        .vld_d (state_n == PS_SKID),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q),
        .vld   (skid_vld)
    );
`else
    assign in_ready = !out_valid || out_ready;
    assign main_d   = {in_ctrl, in_data};
`endif

    pipe_slot #(
        .W (SW)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (ld_main),
        .vld_d (state_n != PS_EMPTY),
        .d     (main_d),
        .q     (main_q),
        .vld   (main_vld)
    );

    assign out_valid = main_vld;
    assign out_data  = main_q[PAYLOAD_W-1:0];
    assign ctrl_main = main_q[SW-1:PAYLOAD_W];
    assign out_ctrl  = out_valid ? ctrl_main : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PS_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next state and slot load strobes; flush drops everything.
    always_comb begin
        state_n = state;
        ld_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        ld_skid = 1'b0;
`endif
        if (flush) begin
            state_n = PS_EMPTY;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        state_n = PS_FULL;
                        ld_main = 1'b1;
                    end
                end
                PS_FULL: begin
                    if (out_xfer && in_xfer) begin
                        ld_main = 1'b1;
                    end else if (out_xfer) begin
                        state_n = PS_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_n = PS_SKID;
                        ld_skid = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PS_SKID: begin
                    if (out_xfer) begin
                        state_n = PS_FULL;
                        ld_main = 1'b1;
                    end
                end
`endif
                default: begin
                    state_n = PS_EMPTY;
                end
            endcase
        end
    end

    // Saturating count of downstream back-pressure cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready
                     && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// Scoreboard of accepted entries checked on every out transfer.
module tb_pipe_stage_reg;

    localparam int PW = 16;
    localparam int CW = 2;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    logic [PW+CW-1:0] sb[$];

    pipe_stage_reg #(
        .PAYLOAD_W (PW),
        .CTRL_W    (CW),
        .CNT_W     (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Mid-cycle scoreboard: occupancy, pop on out xfer, push on in xfer.
    always @(negedge clk) begin
        logic [PW+CW-1:0] exp_e;
        if (rst) begin
            sb.delete();
        end else begin
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                failures++;
                $display("FAIL occupancy: out_valid=%b, model entries=%0d",
                         out_valid, sb.size());
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_e = sb.pop_front();
                checks++;
                if ({out_ctrl, out_data} !== exp_e) begin
                    failures++;
                    $display("FAIL sb_pop: got %h, expected %h",
                             {out_ctrl, out_data}, exp_e);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0055;
        in_ctrl = 2'b11;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (out_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL rst_ctrl: got %b, expected 00", out_ctrl);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rst_cnt: got %0d, expected 0", stall_cnt);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            failures++;
            $display("FAIL rst_data: got %h, expected 0000", out_data);
        end
        rst = 1'b0;
        in_data = 16'h0077;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0077
            || out_ctrl !== 2'b11) begin
            failures++;
            $display("FAIL rst_first_load: got v=%b d=%h c=%b, expected 1 0077 11",
                     out_valid, out_data, out_ctrl);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = 16'(i);
            in_ctrl = 2'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready[%0d]: got %b, expected 1",
                         i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                failures++;
                $display("FAIL stream_out[%0d]: got v=%b d=%h, expected 1 %h",
                         i, out_valid, out_data, 16'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h00AA;
        in_ctrl = 2'b01;
        tick();
        in_data = 16'h00BB;
        in_ctrl = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if (out_data !== 16'h00AA || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: got v=%b d=%h, expected 1 00aa",
                     out_valid, out_data);
        end
        checks++;
        if (stall_cnt !== 4'd5) begin
            failures++;
            $display("FAIL stall_cnt: got %0d, expected 5", stall_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready: got %b, expected 0", in_ready);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00BB) begin
            failures++;
            $display("FAIL stall_release: got v=%b d=%h, expected 1 00bb",
                     out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_empty: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h0011;
        in_ctrl = 2'b11;
        tick();
        in_data = 16'h0022;
        tick();
        flush = 1'b1;
        in_data = 16'h0033;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL flush_kill: got v=%b c=%b, expected 0 00",
                     out_valid, out_ctrl);
        end
        checks++;
        if (stall_cnt !== 4'd2) begin
            failures++;
            $display("FAIL flush_cnt: got %0d, expected 2", stall_cnt);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h0005;
        in_ctrl = 2'b01;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt: got %0d, expected 15", stall_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL sat_flush: got %0d, expected 15", stall_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL sat_rst: got %0d, expected 0", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            in_ctrl = 2'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b, expected 1",
                         i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== in_data) begin
                failures++;
                $display("FAIL b2b_out[%0d]: got v=%b d=%h, expected 1 %h",
                         i, out_valid, out_data, in_data);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom);
            in_data = 16'($urandom);
            in_ctrl = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            #1;
            checks++;
            if (!out_valid && out_ctrl !== 2'b00) begin
                failures++;
                $display("FAIL rand_bubble_ctrl[%0d]: got %b, expected 00",
                         i, out_ctrl);
            end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && out_valid; i++) begin
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_drain: got %b, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
